// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
//   APB4 master that converts a single-outstanding command/response request
//   interface into APB SETUP/ACCESS transfers. Supports write strobes, PSLVERR
//   capture, wait states, an optional PREADY timeout and misaligned-address
//   rejection.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width (8, 16, 32 or 64)
//   TIMEOUT_CYC ACCESS cycles without PREADY before abort; 0 disables
//   CHECK_ALIGN 1 = reject commands with nonzero sub-word address bits
//
// Ports
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/addr/wdata/strb      command payload
//   rsp_valid                      one-cycle completion pulse
//   rsp_rdata/rsp_err/rsp_timeout  response payload (valid with rsp_valid)
//   PSEL..PSTRB                    APB request outputs
//   PREADY/PRDATA/PSLVERR          APB completion inputs
// -----------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  // Sub-word address bits; the mask is empty for an 8-bit bus.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);
  // Count value seen on the last permitted wait-state edge.
  localparam logic [CNT_W-1:0]  CNT_LAST   =
    (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             misaligned;

  assign misaligned = (CHECK_ALIGN != 0) && ((cmd_addr & ALIGN_MASK) != '0);

  // Decoded from registered state; gating with PRESETn keeps the handshake
  // closed during reset and opens it the moment reset is released.
  assign cmd_ready = PRESETn && (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      // rsp_valid is a single-cycle pulse unless a branch below raises it.
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (misaligned) begin
              // Rejected without touching the bus; address/data hold.
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state  <= SETUP;
              PSEL   <= 1'b1;
              PADDR  <= cmd_addr;
              PWRITE <= cmd_write;
              PWDATA <= cmd_write ? cmd_wdata : '0;
              PSTRB  <= cmd_write ? cmd_strb  : '0;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          // PREADY is checked first so it wins over a coincident timeout.
          if (PREADY) begin
            state       <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
          end else if ((TIMEOUT_CYC > 0) && (wait_cnt == CNT_LAST)) begin
            state       <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          // Response fields are only meaningful alongside rsp_valid.
          state       <= IDLE;
          wait_cnt    <= '0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b0;
          rsp_rdata   <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
//   Directed and randomized transfers against apb_master_ctrl (32-bit data,
//   TIMEOUT_CYC = 8). The bench plays the APB slave cycle by cycle and derives
//   expected timing and response values from the transfer rules.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

  localparam int TO = 8;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_paddr;

  apb_master_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(TO),
    .CHECK_ALIGN(1)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete command, entered and left at a falling edge with the DUT
  // idle. waits = PREADY-low ACCESS cycles the slave inserts before ready.
  task automatic do_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int waits, input logic slverr,
                        input logic [31:0] sdata);
    logic        mis, tmo, err;
    logic [31:0] erd;
    int          acc;
    mis = (addr[1:0] != 2'b00);
    tmo = !mis && (waits >= TO);
    acc = tmo ? TO : waits + 1;
    err = mis || tmo || slverr;
    erd = (!err && !wr) ? sdata : 32'h0;

    check("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    @(negedge PCLK);
    // Garbage on the command inputs must be ignored while busy.
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    check("busy_ready", cmd_ready, 0);

    if (mis) begin
      check("rej_valid", rsp_valid, 1);
      check("rej_err", rsp_err, 1);
      check("rej_tmo", rsp_timeout, 0);
      check("rej_rdata", rsp_rdata, 0);
      check("rej_psel", PSEL, 0);
      check("rej_paddr", PADDR, last_paddr);
    end else begin
      check("setup_psel", PSEL, 1);
      check("setup_pen", PENABLE, 0);
      check("setup_paddr", PADDR, addr);
      check("setup_pwrite", PWRITE, wr);
      check("setup_pwdata", PWDATA, wr ? wdata : 32'h0);
      check("setup_pstrb", PSTRB, wr ? strb : 4'h0);
      check("setup_rsp", rsp_valid, 0);
      last_paddr = addr;
      for (int k = 0; k < acc; k++) begin
        @(negedge PCLK);
        check("acc_psel", PSEL, 1);
        check("acc_pen", PENABLE, 1);
        check("acc_paddr", PADDR, addr);
        check("acc_rsp", rsp_valid, 0);
        check("acc_ready", cmd_ready, 0);
        // PSLVERR/PRDATA are noise except on the PREADY edge.
        PREADY  = (k == waits);
        PSLVERR = (k == waits) ? slverr : 1'($urandom);
        PRDATA  = (k == waits) ? sdata  : $urandom;
      end
      @(negedge PCLK);
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = $urandom;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, err);
      check("rsp_tmo", rsp_timeout, tmo);
      check("rsp_rdata", rsp_rdata, erd);
      check("rsp_psel", PSEL, 0);
      check("rsp_pen", PENABLE, 0);
      check("rsp_ready", cmd_ready, 0);
    end

    @(negedge PCLK);
    check("post_ready", cmd_ready, 1);
    check("post_rsp", rsp_valid, 0);
    check("post_psel", PSEL, 0);
    check("post_paddr", PADDR, last_paddr);
  endtask

  initial begin
    PRESETn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_strb   = '0;
    PREADY     = 1'b0;
    PRDATA     = '0;
    PSLVERR    = 1'b0;
    last_paddr = '0;

    #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_psel", PSEL, 0);
    check("rst_pen", PENABLE, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_paddr", PADDR, 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    check("rel_ready", cmd_ready, 1);

    // Zero-wait write.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    // Read with three wait states.
    do_txn(1'b0, 32'h20, 32'h0, 4'hF, 3, 1'b0, 32'h12345678);
    // Read that ends with a slave error.
    do_txn(1'b0, 32'h24, 32'h0, 4'h0, 1, 1'b1, 32'hCAFEF00D);
    // Slave never ready -> timeout, then a normal command.
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 100, 1'b0, 32'h0);
    do_txn(1'b1, 32'h34, 32'hA5A5A5A5, 4'h5, 0, 1'b0, 32'h0);
    // PREADY on the last permitted ACCESS edge beats the timeout.
    do_txn(1'b0, 32'h38, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BADBEEF);
    // Misaligned address.
    do_txn(1'b1, 32'h3, 32'h11111111, 4'hF, 0, 1'b0, 32'h0);

    // Reset asserted mid-ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h40;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    check("mid_acc_pen", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("arst_psel", PSEL, 0);
    check("arst_pen", PENABLE, 0);
    check("arst_ready", cmd_ready, 0);
    check("arst_rsp", rsp_valid, 0);
    repeat (2) begin
      @(negedge PCLK);
      check("inrst_rsp", rsp_valid, 0);
    end
    PRESETn    = 1'b1;
    last_paddr = '0;
    #1;
    check("rel2_ready", cmd_ready, 1);
    check("rel2_rsp", rsp_valid, 0);
    // Back-to-back write then read after release.
    do_txn(1'b1, 32'h100, 32'h01020304, 4'h3, 0, 1'b0, 32'h0);
    do_txn(1'b0, 32'h104, 32'h0, 4'h0, 0, 1'b0, 32'h55AA55AA);

    // Randomized traffic, including timeouts and misaligned addresses.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      do_txn(1'($urandom), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 10), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
Parametrised APB4 master that turns a single-outstanding command/response request interface into compliant APB SETUP/ACCESS transfers. It adds the following over the previous master:
- configurable address and data width
- PSTRB write strobes
- PSLVERR capture
- wait-state handling
- a programmable PREADY timeout
- misaligned-address rejection

It sits between a local controller or register sequencer and the APB slave fabric.

Parameters:
ADDR_W, 32, width of cmd_addr/PADDR
DATA_W, 32, width of data buses; legal values 8, 16, 32, 64
TIMEOUT_CYC, 256, max ACCESS cycles without PREADY before abort; 0 disables timeout
CHECK_ALIGN, 1, 1 = reject commands whose cmd_addr low log2(DATA_W/8) bits are nonzero

Ports:
PCLK  in  1  bus clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a PCLK edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  byte enables for writes
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  PSLVERR, timeout or alignment error
rsp_timeout  out  1  error cause was timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset (PRESETn low, asynchronous): all outputs 0 except cmd_ready; state IDLE; timeout counter 0. cmd_ready is 0 while PRESETn is low and 1 in the first cycle after release.
- Reset mid-transfer: bus outputs drop to 0 immediately. No rsp_valid is issued for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid, the command is registered.
  - Misaligned address with CHECK_ALIGN=1 -> RESP with rsp_err=1, rsp_timeout=0, no bus activity.
  - Otherwise -> SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE, PWDATA, PSTRB come from the registered command.
  - Reads drive PSTRB=0 and PWDATA=0.
  - -> ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, control and data held stable.
  - PREADY sampled at each edge.
  - PREADY=1 -> capture PRDATA (reads only) and PSLVERR, go to RESP.
  - PREADY=0 -> counter increments.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC without PREADY -> abort to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- RESP (1 cycle):
  - rsp_valid=1; PSEL=0, PENABLE=0; cmd_ready=0.
  - Counter cleared; -> IDLE.
- PADDR/PWRITE/PWDATA/PSTRB hold their last values when idle. Only PSEL/PENABLE return to 0.
- Latency: command accepted at edge T -> SETUP in cycle T+1, ACCESS from T+2.
  - With PREADY=1 on the first ACCESS edge, rsp_valid is high in T+3 and cmd_ready is high again in T+4.
  - Minimum 4 cycles between accepts. Each wait state adds 1 cycle.
  - Alignment reject: rsp_valid in T+1.
- There is no response backpressure: the requester must accept rsp_valid when it pulses.
- Command inputs are ignored when cmd_ready=0.
- PSLVERR is honoured only on the PREADY edge. rsp_rdata=0 when PSLVERR=1.
- Timeout with PREADY rising on the same edge: PREADY wins, normal completion.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL 1 for 2 cycles, PENABLE 1 in the second; rsp_valid at T+3, rsp_err=0.
- Read addr 0x20, slave gives PRDATA 0x12345678 after 3 wait states -> PSTRB=0, ACCESS lasts 4 cycles, rsp_rdata=0x12345678, PADDR stable throughout.
- Read with PSLVERR=1 on the PREADY edge -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYC=8, PREADY held 0 -> after 8 ACCESS cycles PSEL/PENABLE drop; rsp_valid with rsp_err=1, rsp_timeout=1; next command accepted normally.
- cmd_addr 0x3 with DATA_W=32 -> no PSEL assertion, rsp_valid at T+1 with rsp_err=1.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE 0 asynchronously, no rsp_valid; a back-to-back write then read after release both complete, with cmd_ready gaps of exactly 3 cycles.
